// File: rtl/reg_file_flags.sv
// Register file and flags register for the 8-bit one-cycle processor.
// Two combinational read ports feed the ALU operands. One synchronous write port takes the
// write-back result. r0 is hardwired to zero. A separate flags register captures the ALU
// {zero, sign, overflow} output.
// Optional build macro REGFILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file_flags #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 3,
  parameter int unsigned FLAG_WIDTH = 3
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic        [ADDR_WIDTH-1:0] rd_addr_a,
  output logic signed [DATA_WIDTH-1:0] rd_data_a,
  input  logic        [ADDR_WIDTH-1:0] rd_addr_b,
  output logic signed [DATA_WIDTH-1:0] rd_data_b,
  input  logic                         wr_en,
  input  logic        [ADDR_WIDTH-1:0] wr_addr,
  input  logic        [DATA_WIDTH-1:0] wr_data,
  input  logic                         flags_we,
  input  logic        [FLAG_WIDTH-1:0] flags_in,
  output logic        [FLAG_WIDTH-1:0] flags_out
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  // Entry 0 is never written, so it stays at its reset value and synthesis reduces it to a constant.
  logic [DATA_WIDTH-1:0] regs_q [NumRegs];
  logic [FLAG_WIDTH-1:0] flags_q;
  logic                  wr_fire;

  // A write takes effect only outside reset and never targets r0.
  assign wr_fire = wr_en && !reset && (wr_addr != '0);

  // Register storage: reset clears every entry; otherwise the addressed entry takes wr_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_fire) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  // Flags capture is independent of write-back, so compare-type operations can update flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      flags_q <= '0;
    end else if (flags_we) begin
      flags_q <= flags_in;
    end
  end

  assign flags_out = flags_q;

  // Read port A: r0 reads as zero. An optional forward from the write port applies.
  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != '0) begin
      rd_data_a = regs_q[rd_addr_a];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_fire && (rd_addr_a == wr_addr)) begin
      rd_data_a = wr_data;
    end
`endif
  end

  // Read port B: same behaviour as port A, evaluated independently.
  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != '0) begin
      rd_data_b = regs_q[rd_addr_b];
    end
`ifdef REGFILE_BYPASS_EN
    if (wr_fire && (rd_addr_b == wr_addr)) begin
      rd_data_b = wr_data;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_flags.sv
// Self-checking bench for reg_file_flags.
// The reference model is a plain array of register values plus one flags value, updated from
// the architectural rules on every clock edge.
module tb_reg_file_flags;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int FW = 3;
  localparam int NR = 8;

  logic                 clk;
  logic                 reset;
  logic        [AW-1:0] rd_addr_a;
  logic signed [DW-1:0] rd_data_a;
  logic        [AW-1:0] rd_addr_b;
  logic signed [DW-1:0] rd_data_b;
  logic                 wr_en;
  logic        [AW-1:0] wr_addr;
  logic        [DW-1:0] wr_data;
  logic                 flags_we;
  logic        [FW-1:0] flags_in;
  logic        [FW-1:0] flags_out;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state.
  logic [DW-1:0] model_regs [NR];
  logic [FW-1:0] model_flags;

  reg_file_flags #(
    .DATA_WIDTH(DW),
    .ADDR_WIDTH(AW),
    .FLAG_WIDTH(FW)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr_a(rd_addr_a),
    .rd_data_a(rd_data_a),
    .rd_addr_b(rd_addr_b),
    .rd_data_b(rd_data_b),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .flags_we (flags_we),
    .flags_in (flags_in),
    .flags_out(flags_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected read value for the currently driven inputs.
  function automatic logic [DW-1:0] exp_read(input logic [AW-1:0] addr);
    if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
    if (wr_en && !reset && wr_addr == addr) return wr_data;
`endif
    return model_regs[addr];
  endfunction

  // Advance one clock edge and apply the architectural update rules to the model.
  task automatic tick();
    logic [DW-1:0] nxt [NR];
    logic [FW-1:0] nflags;
    for (int i = 0; i < NR; i++) nxt[i] = model_regs[i];
    nflags = model_flags;
    if (reset) begin
      for (int i = 0; i < NR; i++) nxt[i] = '0;
      nflags = '0;
    end else begin
      if (wr_en && wr_addr != 0) nxt[wr_addr] = wr_data;
      if (flags_we) nflags = flags_in;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NR; i++) model_regs[i] = nxt[i];
    model_flags = nflags;
  endtask

  task automatic idle_inputs();
    reset    = 1'b0;
    wr_en    = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    flags_we = 1'b0;
    flags_in = '0;
  endtask

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = AW'(i);
      rd_addr_b = AW'(NR - 1 - i);
      #1;
      n_checks++;
      if (rd_data_a !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_read_a addr=%0d got=%h want=00", i, rd_data_a);
      end
      n_checks++;
      if (rd_data_b !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_read_b addr=%0d got=%h want=00", NR - 1 - i, rd_data_b);
      end
    end
    n_checks++;
    if (flags_out !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_flags got=%b want=000", flags_out);
    end
  endtask

  task automatic test_write_dual_read();
    write_reg(3'd3, 8'h7F);
    write_reg(3'd5, 8'h80);
    rd_addr_a = 3'd3;
    rd_addr_b = 3'd5;
    #1;
    n_checks++;
    if (rd_data_a !== 8'h7F) begin
      n_fail++;
      $display("FAIL dual_read_a got=%h want=7f", rd_data_a);
    end
    n_checks++;
    if (rd_data_b !== 8'h80) begin
      n_fail++;
      $display("FAIL dual_read_b got=%h want=80", rd_data_b);
    end
    rd_addr_a = 3'd5;
    #1;
    n_checks++;
    if (rd_data_a !== 8'h80 || rd_data_b !== 8'h80) begin
      n_fail++;
      $display("FAIL same_addr_read a=%h b=%h want=80", rd_data_a, rd_data_b);
    end
  endtask

  task automatic test_r0_protect();
    wr_en     = 1'b1;
    wr_addr   = 3'd0;
    wr_data   = 8'hAA;
    rd_addr_a = 3'd0;
    #1;
    n_checks++;
    if (rd_data_a !== 8'h00) begin
      n_fail++;
      $display("FAIL r0_during_write got=%h want=00", rd_data_a);
    end
    tick();
    wr_en = 1'b0;
    for (int i = 0; i < NR; i++) begin
      rd_addr_a = AW'(i);
      #1;
      n_checks++;
      if (rd_data_a !== exp_read(AW'(i))) begin
        n_fail++;
        $display("FAIL r0_protect addr=%0d got=%h want=%h", i, rd_data_a, exp_read(AW'(i)));
      end
    end
  endtask

  task automatic test_hazard();
    logic [DW-1:0] before_exp;
    write_reg(3'd2, 8'h11);
`ifdef REGFILE_BYPASS_EN
    before_exp = 8'h22;
`else
    before_exp = 8'h11;
`endif
    wr_en     = 1'b1;
    wr_addr   = 3'd2;
    wr_data   = 8'h22;
    rd_addr_a = 3'd2;
    #1;
    n_checks++;
    if (rd_data_a !== before_exp) begin
      n_fail++;
      $display("FAIL hazard_before got=%h want=%h", rd_data_a, before_exp);
    end
    tick();
    wr_en = 1'b0;
    #1;
    n_checks++;
    if (rd_data_a !== 8'h22) begin
      n_fail++;
      $display("FAIL hazard_after got=%h want=22", rd_data_a);
    end
  endtask

  task automatic test_flags();
    flags_we = 1'b1;
    flags_in = 3'b101;
    tick();
    n_checks++;
    if (flags_out !== 3'b101) begin
      n_fail++;
      $display("FAIL flags_capture got=%b want=101", flags_out);
    end
    flags_we = 1'b0;
    flags_in = 3'b010;
    tick();
    n_checks++;
    if (flags_out !== 3'b101) begin
      n_fail++;
      $display("FAIL flags_hold got=%b want=101", flags_out);
    end
  endtask

  task automatic test_reset_mid();
    reset     = 1'b1;
    wr_en     = 1'b1;
    wr_addr   = 3'd4;
    wr_data   = 8'h33;
    flags_we  = 1'b1;
    flags_in  = 3'b111;
    rd_addr_a = 3'd4;
    #1;
    // Bypass is suppressed in reset, so r4 shows its stored value (zero here).
    n_checks++;
    if (rd_data_a !== exp_read(3'd4) || rd_data_a !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_cycle_read got=%h want=00", rd_data_a);
    end
    tick();
    idle_inputs();
    for (int i = 0; i < NR; i++) begin
      rd_addr_b = AW'(i);
      #1;
      n_checks++;
      if (rd_data_b !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_mid_reg addr=%0d got=%h want=00", i, rd_data_b);
      end
    end
    n_checks++;
    if (flags_out !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_mid_flags got=%b want=000", flags_out);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      reset    = ($urandom_range(0, 24) == 0);
      wr_en    = ($urandom_range(0, 3) != 0);
      wr_addr  = AW'($urandom);
      wr_data  = DW'($urandom);
      flags_we = ($urandom_range(0, 2) == 0);
      flags_in = FW'($urandom);
      rd_addr_a = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      rd_addr_b = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom);
      #1;
      n_checks++;
      if (rd_data_a !== exp_read(rd_addr_a)) begin
        n_fail++;
        $display("FAIL rand_read_a iter=%0d addr=%0d got=%h want=%h", n, rd_addr_a, rd_data_a,
                 exp_read(rd_addr_a));
      end
      n_checks++;
      if (rd_data_b !== exp_read(rd_addr_b)) begin
        n_fail++;
        $display("FAIL rand_read_b iter=%0d addr=%0d got=%h want=%h", n, rd_addr_b, rd_data_b,
                 exp_read(rd_addr_b));
      end
      n_checks++;
      if (flags_out !== model_flags) begin
        n_fail++;
        $display("FAIL rand_flags iter=%0d got=%b want=%b", n, flags_out, model_flags);
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    for (int i = 0; i < NR; i++) model_regs[i] = '0;
    model_flags = '0;
    rd_addr_a   = '0;
    rd_addr_b   = '0;
    idle_inputs();
    #2;
    test_reset();
    test_write_dual_read();
    test_r0_protect();
    test_hazard();
    test_flags();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_flags.md
# reg_file_flags

Architectural register file and flags register for the 8-bit one-cycle processor. Sits directly upstream of the ALU: two combinational read ports drive the ALU `a` and `b` operands, and one synchronous write port takes the write-back result. A companion flags register captures the ALU's 3-bit `{zero, sign, overflow}` output for later branch and condition evaluation.

## Interface
- `DATA_WIDTH`, default 8: register and operand width, matching the ALU operands.
- `ADDR_WIDTH`, default 3: register address width; the file holds 2^ADDR_WIDTH registers (r0..r7).
- `FLAG_WIDTH`, default 3: flags width, `{zero, sign, overflow}`, matching ALU `flags[2:0]`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `rd_addr_a`  in  ADDR_WIDTH  read port A address.
- `rd_data_a`  out  DATA_WIDTH  read port A data, signed, drives ALU `a`.
- `rd_addr_b`  in  ADDR_WIDTH  read port B address.
- `rd_data_b`  out  DATA_WIDTH  read port B data, signed, drives ALU `b`.
- `wr_en`  in  1  write-back enable.
- `wr_addr`  in  ADDR_WIDTH  write-back address.
- `wr_data`  in  DATA_WIDTH  write-back data (ALU `result`).
- `flags_we`  in  1  flags capture enable.
- `flags_in`  in  FLAG_WIDTH  ALU `flags`.
- `flags_out`  out  FLAG_WIDTH  registered flags.

## Operation
- Storage: 2^ADDR_WIDTH registers of DATA_WIDTH bits, plus one FLAG_WIDTH flags register.
- r0 is hardwired to zero:
  - reads of address 0 always return 0;
  - writes to address 0 are discarded, and the address-0 entry need not be stored.
- Reads: purely combinational from `rd_addr_*` and stored state; no read enable.
  - Both ports may address the same register and both return the same value.
- Write: on a rising edge with `wr_en=1`, `reset=0`, `wr_addr!=0`, the addressed register takes `wr_data`. All other registers hold.
- Flags: on a rising edge with `flags_we=1`, `reset=0`, `flags_out` takes `flags_in`. Otherwise `flags_out` holds.
  - Flags capture is independent of `wr_en`, so compare-style operations can update flags without writing back.
- Reset: on a rising edge with `reset=1`, all registers clear to 0 and `flags_out` clears to 0.
  - Reset has priority: any write or flags capture in the same cycle is dropped.
- Reset mid-program: the state is lost. The register and flags values after that edge are all 0, regardless of any prior contents.
- Arithmetic: none. Values are stored and forwarded bit-exact, with no sign extension or truncation.

## Timing
- Read latency: 0 cycles. `rd_data_*` follows `rd_addr_*` combinationally.
- Write latency: 1 edge. Without bypass, a register written at edge N reads the new value from just after edge N.
- Same-cycle read and write to the same address: behaviour is defined by the Configuration section.
- Flags latency: 1 edge. `flags_out` shows the captured value from just after the capture edge.
- Output values after reset: `rd_data_a = rd_data_b = 0` for any address, and `flags_out = 0`.
- Before the first reset, contents are undefined. The bench must assert reset for at least one edge.

## Configuration
- `REGFILE_BYPASS_EN` defined:
  - when `wr_en=1`, `reset=0`, `wr_addr!=0` and `rd_addr_x==wr_addr`, `rd_data_x` returns `wr_data` combinationally in the same cycle;
  - this applies per port, independently;
  - bypass never applies to r0;
  - bypass is suppressed while `reset=1`.
- `REGFILE_BYPASS_EN` undefined: a read always returns the stored value. A same-cycle write becomes visible only after the edge.
- Storage, reset and flags behaviour are identical in both builds.

## Test plan
- Reset then read: assert `reset` for 1 edge, then read all addresses 0..7 on both ports → every read is 0x00 and `flags_out=3'b000`.
- Write and dual read: write r3=0x7F, then r5=0x80; read A=3, B=5 → `rd_data_a=0x7F`, `rd_data_b=0x80`. Read A=B=5 → both 0x80.
- r0 protection: write r0=0xAA with `wr_en=1` → reading address 0 returns 0x00, and every other register is unchanged.
- Same-cycle hazard: r2 holds 0x11; drive `wr_en=1`, `wr_addr=2`, `wr_data=0x22`, `rd_addr_a=2`.
  - Before the edge: `rd_data_a=0x22` with `REGFILE_BYPASS_EN`, 0x11 without.
  - After the edge: 0x22 in both builds.
- Flags capture and priority:
  - `flags_we=1`, `flags_in=3'b101` → `flags_out=3'b101` after the edge.
  - `flags_we=0`, `flags_in=3'b010` → `flags_out` stays 3'b101.
- Reset mid-operation: drive `reset=1` together with `wr_en=1`, `wr_addr=4`, `wr_data=0x33`, `flags_we=1`, `flags_in=3'b111` → after the edge, r4=0x00 and `flags_out=3'b000`; with bypass built in, `rd_data` for address 4 reads 0x00 during the reset cycle.
